// File: rtl/mmio_timer_if.sv
// Data-memory bus segment between the core (master) and the timer (slave).
// Combinational read data and the address-hit flag are returned in the same cycle.
interface mmio_timer_if;
    logic        i_we_w;
    logic [31:0] i_a_w;
    logic [31:0] i_wd_w;
    logic [31:0] o_rd_w;
    logic        o_sel_w;
    logic        o_irq_w;

    modport master (
        output i_we_w, i_a_w, i_wd_w,
        input  o_rd_w, o_sel_w, o_irq_w
    );

    modport slave (
        input  i_we_w, i_a_w, i_wd_w,
        output o_rd_w, o_sel_w, o_irq_w
    );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped timer/compare peripheral on the core's data bus: prescaled counter,
// sticky compare-match flag and a level interrupt.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic         i_clk_w,
    input  logic         i_rst_w,
    mmio_timer_if.slave  bus
);
    localparam logic [PRESCALE_W-1:0] PRE_ONE = 1;

    logic                  r_en;
    logic                  r_auto;
    logic                  r_irq_en;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pre_cnt;
    logic [31:0]           r_count;
    logic [31:0]           r_compare;
    logic                  r_match;

    logic        w_sel;
    logic [2:0]  w_off;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_pre;
    logic        w_wr_cnt;
    logic        w_wr_cmp;
    logic        w_wr_stat;
    logic        w_tick;
    logic        w_hit;
    logic [31:0] w_rd;
    logic        w_unused_ok;

    assign w_sel       = (bus.i_a_w[31:5] == BASE_ADDR[31:5]);
    assign w_off       = bus.i_a_w[4:2];
    assign w_unused_ok = &{1'b0, bus.i_a_w[1:0]};
    assign w_wr        = bus.i_we_w & w_sel;
    assign w_wr_ctrl   = w_wr && (w_off == 3'd0);
    assign w_wr_pre    = w_wr && (w_off == 3'd1);
    assign w_wr_cnt    = w_wr && (w_off == 3'd2);
    assign w_wr_cmp    = w_wr && (w_off == 3'd3);
    assign w_wr_stat   = w_wr && (w_off == 3'd4);

    // A PRESCALE write restarts the divider and swallows the tick of that edge.
    assign w_tick = r_en && (r_pre_cnt == r_prescale) && !w_wr_pre;
    assign w_hit  = w_tick && (r_count == r_compare);

    always_ff @(posedge i_clk_w) begin
        if (i_rst_w) begin
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_prescale <= '0;
            r_pre_cnt  <= '0;
            r_count    <= '0;
            r_compare  <= '0;
            r_match    <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en     <= bus.i_wd_w[0];
                r_auto   <= bus.i_wd_w[1];
                r_irq_en <= bus.i_wd_w[2];
            end

            if (w_wr_pre) begin
                r_prescale <= bus.i_wd_w[PRESCALE_W-1:0];
                r_pre_cnt  <= '0;
            end else if (r_en) begin
                r_pre_cnt <= (r_pre_cnt == r_prescale) ? '0 : r_pre_cnt + PRE_ONE;
            end

            // CPU write to COUNT overrides the tick increment of the same edge.
            if (w_wr_cnt) begin
                r_count <= bus.i_wd_w;
            end else if (w_tick) begin
                r_count <= (w_hit && r_auto) ? '0 : r_count + 32'd1;
            end

            if (w_wr_cmp) begin
                r_compare <= bus.i_wd_w;
            end

            // Match set beats a simultaneous write-1-clear.
            if (w_hit) begin
                r_match <= 1'b1;
            end else if (w_wr_stat && bus.i_wd_w[0]) begin
                r_match <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd = '0;
        if (w_sel) begin
            case (w_off)
                3'd0:    w_rd = {29'd0, r_irq_en, r_auto, r_en};
                3'd1:    w_rd[PRESCALE_W-1:0] = r_prescale;
                3'd2:    w_rd = r_count;
                3'd3:    w_rd = r_compare;
                3'd4:    w_rd = {31'd0, r_match};
                default: w_rd = '0;
            endcase
        end
    end

    assign bus.o_rd_w  = w_rd;
    assign bus.o_sel_w = w_sel;
    assign bus.o_irq_w = r_match & r_irq_en;
endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped timer/compare peripheral that sits on the single-cycle MIPS core's data-memory bus, alongside DMEM.
- The core is the initiator and issues sw/lw; this block is the responder.
- It decodes its own address window, accepts register writes on the clock edge and returns read data combinationally, in the same cycle as the request.
- It counts prescaled clock ticks, flags compare matches in a sticky status bit and raises an interrupt level.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, base of the 32-byte register window; bits [4:0] must be zero.
- PRESCALE_W, 16, width of the prescaler divider register and its internal counter.

Ports:
- i_clk_w  in  1  system clock; all state updates on the rising edge.
- i_rst_w  in  1  synchronous, active-high reset.
- i_we_w  in  1  store strobe from the core (mem_write).
- i_a_w  in  32  byte address from the core (ALU out).
- i_wd_w  in  32  store data from the core.
- o_rd_w  out  32  read data, combinational; 0 when the address is not selected.
- o_sel_w  out  1  combinational address hit; the top level uses it to mux o_rd_w against DMEM and to gate DMEM writes.
- o_irq_w  out  1  registered-state interrupt level.

Behaviour:
- Address decode
  - Select when i_a_w[31:5] == BASE_ADDR[31:5].
  - Register offset is i_a_w[4:2]; i_a_w[1:0] is ignored.
  - A write takes effect only when i_we_w and o_sel_w are both 1.
- Register map (offset: register, reset value)
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; bits [31:3] read 0. Reset 0.
  - 0x04 PRESCALE: bits [PRESCALE_W-1:0] hold the divider; upper bits read 0. Reset 0.
  - 0x08 COUNT: 32-bit counter. Reset 0.
  - 0x0C COMPARE: 32-bit compare value. Reset 0.
  - 0x10 STATUS: bit0 MATCH, sticky; writing 1 clears it, writing 0 has no effect. Reset 0.
  - 0x14-0x1C: read 0; writes ignored.
- Reads
  - Purely combinational from current register state.
  - A read in the same cycle as a write returns the pre-edge value.
- Prescaler
  - Internal counter pre_cnt, reset 0.
  - With EN=1: if pre_cnt == PRESCALE, pre_cnt goes to 0 and a tick occurs this cycle; otherwise pre_cnt increments.
  - PRESCALE=0 gives a tick every cycle; PRESCALE=N gives a tick every N+1 cycles.
  - With EN=0, pre_cnt and COUNT hold their values.
- Tick action
  - If COUNT == COMPARE: MATCH is set to 1. COUNT goes to 0 if AUTO_RELOAD=1, otherwise COUNT+1.
  - Otherwise COUNT goes to COUNT+1.
  - Arithmetic is modulo 2^32: 0xFFFF_FFFF wraps to 0 with no flag.
- Simultaneous events
  - CPU write to COUNT coincides with a tick: the written value wins and the tick's increment is lost.
  - CPU write to PRESCALE: pre_cnt is forced to 0 on the same edge and no tick occurs that cycle.
  - CPU write to COMPARE coincides with a tick: the match check uses the old COMPARE.
  - STATUS write-1-clear in the same cycle as a match set: the set wins and MATCH stays 1.
  - Writing CTRL.EN=0 on a tick edge: that tick still completes; counting stops from the next cycle.
- Interrupt
  - o_irq_w = MATCH & IRQ_EN, combinational from registered state (no data-bus inputs in its path).
  - Clearing IRQ_EN masks the output without clearing MATCH.
- Reset
  - i_rst_w=1 at any edge, including mid-count, clears CTRL, PRESCALE, COUNT, COMPARE, MATCH and pre_cnt.
  - Reset has priority over any simultaneous write.
  - o_irq_w=0 from the first edge with reset asserted.
  - o_rd_w and o_sel_w follow the address with no reset dependence.

Test Plan:
- Reset, then lw from 0xFFFF_0000..0xFFFF_001C -> all reads return 0. lw from 0x1000_0000 -> o_sel_w=0, o_rd_w=0. sw to 0x1000_0008 -> timer state unchanged.
- PRESCALE=3, COMPARE=2, CTRL=0x1 -> COUNT reads 1, 2, 3 at 4, 8 and 12 cycles after EN. MATCH=1 on the edge COUNT 2->3. o_irq_w stays 0 because IRQ_EN=0.
- CTRL=0x7, PRESCALE=0, COMPARE=5 -> COUNT runs 0..5, then 0. MATCH and o_irq_w go to 1 on the wrap edge. sw STATUS=1 -> o_irq_w=0 next cycle.
- COUNT=0xFFFF_FFFE, PRESCALE=0, EN=1, COMPARE=0x10 -> reads 0xFFFF_FFFF, then 0x0, then 0x1. MATCH stays 0.
- Simultaneous events:
  - sw COUNT=0x100 on a tick edge -> COUNT reads 0x100, not 0x101.
  - sw STATUS=1 on the match-set edge -> MATCH reads 1.
  - lw COUNT in the same cycle as sw COUNT -> returns the old value.
- Run with COUNT=0x40, CTRL=0x7, MATCH=1, then pulse i_rst_w for one cycle -> every register reads 0 and o_irq_w=0 on the next cycle. Counting stays halted until EN is rewritten.
